// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//  - FSM state encodings
//  - control-transfer kind codes
//  - forwarding select encodings
//  - bubble-count width and clamp helper
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CT_STALL = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CT_BR  = 2'd0,
        CT_J   = 2'd1,
        CT_JAL = 2'd2,
        CT_JR  = 2'd3
    } ct_kind_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int BUB_W = 8;

    // A bubble count of 0 would never leave CT_STALL cleanly, so it is
    // raised to 1; oversized counts saturate at the counter range.
    function automatic logic [BUB_W-1:0] bubbles_clamp(input int n);
        logic [BUB_W-1:0] r;
        if (n < 1) begin
            r = {{(BUB_W-1){1'b0}}, 1'b1};
        end else if (n > 255) begin
            r = {BUB_W{1'b1}};
        end else begin
            r = n[BUB_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding comparator for one EXE operand.
//  exe_src      in  source register of the EXE operand
//  mem_rw/_regwrite, wb_rw/_regwrite  in  downstream writers
//  fwd_sel      out FWD_MEM / FWD_WB / FWD_RF (MEM is the younger result)
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] exe_src,
    input  logic [REG_ADDR_W-1:0] mem_rw,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rw,
    input  logic                  wb_regwrite,
    output logic [1:0]            fwd_sel
);

    // Select the youngest in-flight producer of exe_src; r0 is never forwarded.
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_regwrite && (mem_rw != '0) && (mem_rw == exe_src)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rw != '0) && (wb_rw == exe_src)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage pipeline.
//  clk, init (async active-low)          state changes on negedge clk
//  dec_*                                  ID-stage operands and control-transfer flags
//  exe_*, mem_*, wb_*                     downstream register usage
//  pc_en, ifid_en, idex_clear             pipeline enables / squash
//  fwd_a_sel, fwd_b_sel                   EXE operand forwarding selects
//  busy                                   FSM outside IDLE
//  stall_cnt                              saturating count of cycles with pc_en = 0
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = 5,
    parameter int BR_BUBBLES    = 3,
    parameter int J_BUBBLES     = 2,
    parameter int JAL_BUBBLES   = 3,
    parameter int JR_BUBBLES    = 2,
    parameter int EARLY_RELEASE = 1,
    parameter int STAT_W        = 16
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic [REG_ADDR_W-1:0] dec_rs,
    input  logic [REG_ADDR_W-1:0] dec_rt,
    input  logic                  dec_uses_rt,
    input  logic                  dec_branch,
    input  logic                  dec_jump,
    input  logic                  dec_jal,
    input  logic                  dec_jr,
    input  logic [REG_ADDR_W-1:0] exe_rs,
    input  logic [REG_ADDR_W-1:0] exe_rt,
    input  logic [REG_ADDR_W-1:0] exe_rw,
    input  logic                  exe_regwrite,
    input  logic                  exe_is_load,
    input  logic                  exe_br_resolved,
    input  logic [REG_ADDR_W-1:0] mem_rw,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rw,
    input  logic                  wb_regwrite,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_clear,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  busy,
    output logic [STAT_W-1:0]     stall_cnt
);

    localparam logic [BUB_W-1:0] BR_N  = bubbles_clamp(BR_BUBBLES);
    localparam logic [BUB_W-1:0] J_N   = bubbles_clamp(J_BUBBLES);
    localparam logic [BUB_W-1:0] JAL_N = bubbles_clamp(JAL_BUBBLES);
    localparam logic [BUB_W-1:0] JR_N  = bubbles_clamp(JR_BUBBLES);

    state_t            state_r, state_n_s;
    ct_kind_t          kind_r, kind_n_s;
    logic [BUB_W-1:0]  bub_r, bub_n_s;
    logic [STAT_W-1:0] stall_cnt_r;
    logic              lu_s, ct_any_s;
    logic              pc_en_s, ifid_en_s, idex_clear_s;
    logic [1:0]        fwd_a_raw_s, fwd_b_raw_s;

    hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .exe_src(exe_rs), .mem_rw(mem_rw), .mem_regwrite(mem_regwrite),
        .wb_rw(wb_rw), .wb_regwrite(wb_regwrite), .fwd_sel(fwd_a_raw_s)
    );

    hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .exe_src(exe_rt), .mem_rw(mem_rw), .mem_regwrite(mem_regwrite),
        .wb_rw(wb_rw), .wb_regwrite(wb_regwrite), .fwd_sel(fwd_b_raw_s)
    );

    // Load-use detection against the ID-stage operands.
    always_comb begin
        lu_s = exe_is_load && exe_regwrite && (exe_rw != '0) &&
               ((exe_rw == dec_rs) || (dec_uses_rt && (exe_rw == dec_rt)));
        ct_any_s = dec_branch | dec_jump | dec_jal | dec_jr;
    end

    // FSM next state, bubble counter and pipeline controls; reset forces outputs.
    always_comb begin
        state_n_s    = state_r;
        kind_n_s     = kind_r;
        bub_n_s      = bub_r;
        pc_en_s      = 1'b1;
        ifid_en_s    = 1'b1;
        idex_clear_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (lu_s) begin
                    pc_en_s      = 1'b0;
                    ifid_en_s    = 1'b0;
                    idex_clear_s = 1'b1;
                end else if (ct_any_s) begin
                    // Freeze fetch but let the transfer itself move into EXE.
                    pc_en_s   = 1'b0;
                    ifid_en_s = 1'b0;
                    state_n_s = CT_STALL;
                    if (dec_jr) begin
                        kind_n_s = CT_JR;
                        bub_n_s  = JR_N;
                    end else if (dec_jal) begin
                        kind_n_s = CT_JAL;
                        bub_n_s  = JAL_N;
                    end else if (dec_jump) begin
                        kind_n_s = CT_J;
                        bub_n_s  = J_N;
                    end else begin
                        kind_n_s = CT_BR;
                        bub_n_s  = BR_N;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            CT_STALL: begin
                pc_en_s      = 1'b0;
                ifid_en_s    = 1'b0;
                idex_clear_s = 1'b1;
                bub_n_s      = bub_r - BUB_W'(1);
                if ((EARLY_RELEASE != 0) && (kind_r == CT_BR) && exe_br_resolved) begin
                    state_n_s = RELEASE;
                end else if (bub_r <= BUB_W'(1)) begin
                    state_n_s = RELEASE;
                end else begin
                    state_n_s = CT_STALL;
                end
            end
            RELEASE: begin
                // IF_ID still holds the pre-transfer fetch; squash it as it moves on.
                idex_clear_s = 1'b1;
                state_n_s    = IDLE;
            end
            default: begin
                pc_en_s      = 1'b0;
                ifid_en_s    = 1'b0;
                idex_clear_s = 1'b1;
                state_n_s    = IDLE;
            end
        endcase
        if (!init) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_clear_s = 1'b1;
        end else begin
            pc_en_s      = pc_en_s;
        end
    end

    // State, bubble counter and stall statistics.
    always_ff @(negedge clk or negedge init) begin
        if (!init) begin
            state_r     <= IDLE;
            kind_r      <= CT_BR;
            bub_r       <= '0;
            stall_cnt_r <= '0;
        end else begin
            state_r <= state_n_s;
            kind_r  <= kind_n_s;
            bub_r   <= bub_n_s;
            if (!pc_en_s && (stall_cnt_r != {STAT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + STAT_W'(1);
            end
        end
    end

    // Output drive; forwarding is forced to the register file during reset.
    always_comb begin
        pc_en      = pc_en_s;
        ifid_en    = ifid_en_s;
        idex_clear = idex_clear_s;
        busy       = (state_r != IDLE);
        stall_cnt  = stall_cnt_r;
        if (init) begin
            fwd_a_sel = fwd_a_raw_s;
            fwd_b_sel = fwd_b_raw_s;
        end else begin
            fwd_a_sel = FWD_RF;
            fwd_b_sel = FWD_RF;
        end
    end

endmodule
